// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, instruction field positions and fetch state encoding
package mips_pkg;

  localparam logic [2:0] OP_RFORMAT = 3'b001;
  localparam logic [2:0] OP_LW      = 3'b010;
  localparam logic [2:0] OP_SW      = 3'b011;
  localparam logic [2:0] OP_J       = 3'b100;
  localparam logic [2:0] OP_BEQ     = 3'b101;
  localparam logic [2:0] OP_BNE     = 3'b110;
  localparam logic [2:0] OP_ADDI    = 3'b111;

  localparam int OPC_LSB  = 26;
  localparam int IMM_MSB  = 15;
  localparam int JTGT_MSB = 25;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_STEP_DEFAULT  = 4;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_t;

  // Sign-extended 16-bit immediate, scaled to a byte offset
  function automatic logic [31:0] branch_offset(input logic [IMM_MSB:0] imm);
    return {{14{imm[IMM_MSB]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-pc selection for sequential, branch and jump
module pc_next_calc
  import mips_pkg::*;
#(
  parameter int PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [31:0]       pc,
  input  logic [JTGT_MSB:0] instr_idx,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic              zero,
  input  logic              jump,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       next_pc
);

  logic taken;

  assign pc_plus4 = pc + 32'(PC_STEP);
  // beq/bne both high is OR-ed rather than rejected
  assign taken    = (branch & zero) | (branch_ne & ~zero);

  // Jump outranks branch, branch outranks sequential; all arithmetic wraps mod 2^32
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
    end else if (taken) begin
      next_pc = pc_plus4 + branch_offset(instr_idx[IMM_MSB:0]);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - pc owner, req/ack instruction fetch and issue hold
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic        jump
);

  fetch_state_t state, state_nx;
  logic         started;
  logic         load_instr;
  logic         take_next;
  logic [31:0]  next_pc;

  pc_next_calc #(
    .PC_STEP(PC_STEP)
  ) u_pc_next_calc (
    .pc        (pc),
    .instr_idx (instr[JTGT_MSB:0]),
    .branch    (branch),
    .branch_ne (branch_ne),
    .zero      (zero),
    .jump      (jump),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

  // The first cycle after reset keeps the request low so a late ack from an
  // abandoned fetch cannot be mistaken for the restart fetch
  assign imem_req  = (state == FETCH) && started;
  assign imem_addr = pc;

  // Next-state and register-load enables
  always_comb begin
    state_nx   = state;
    load_instr = 1'b0;
    take_next  = 1'b0;
    case (state)
      FETCH: begin
        if (started && imem_ack) begin
          load_instr = 1'b1;
          state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        if (advance) begin
          take_next = 1'b1;
          state_nx  = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  // State, pc, instruction and valid registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= FETCH;
      started     <= 1'b0;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
      if (load_instr) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (take_next) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        branch;
  logic        branch_ne;
  logic        zero;
  logic        jump;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .advance     (advance),
    .branch      (branch),
    .branch_ne   (branch_ne),
    .zero        (zero),
    .jump        (jump)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expect a request at exp_addr, answer it with zero wait, and check the issue state
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
    check({tag, "_req"}, {31'h0, imem_req}, 32'h1);
    check({tag, "_addr"}, imem_addr, exp_addr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    check({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    check({tag, "_instr"}, instr, word);
    check({tag, "_pc"}, pc, exp_addr);
    check({tag, "_req_low"}, {31'h0, imem_req}, 32'h0);
  endtask

  task automatic do_issue(input logic b, input logic bn, input logic z, input logic j);
    branch    = b;
    branch_ne = bn;
    zero      = z;
    jump      = j;
    advance   = 1'b1;
    tick();
    advance   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    zero      = 1'b0;
    jump      = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    advance    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    zero       = 1'b0;
    jump       = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    reset_n = 1'b1;
    tick();
    check("start_valid", {31'h0, instr_valid}, 32'h0);

    // Sequential fetch with zero-wait memory
    do_fetch("seq0", 32'h0000_0000, 32'hA000_0000);
    do_issue(0, 0, 0, 0);
    check("seq1_valid_low", {31'h0, instr_valid}, 32'h0);
    do_fetch("seq1", 32'h0000_0004, 32'hA000_0001);

    // Hold in ISSUE: stray ack and new rdata must not disturb anything
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    imem_ack = 1'b0;
    check("hold_instr", instr, 32'hA000_0001);
    check("hold_valid", {31'h0, instr_valid}, 32'h1);
    check("hold_pc", pc, 32'h0000_0004);
    check("hold_req", {31'h0, imem_req}, 32'h0);
    do_issue(0, 0, 0, 0);

    // Ack delayed three cycles at pc=8
    for (int i = 0; i < 3; i++) begin
      check("wait_req", {31'h0, imem_req}, 32'h1);
      check("wait_addr", imem_addr, 32'h0000_0008);
      check("wait_instr", instr, 32'hA000_0001);
      check("wait_valid", {31'h0, instr_valid}, 32'h0);
      tick();
    end
    do_fetch("late", 32'h0000_0008, 32'hA000_0002);
    do_issue(0, 0, 0, 0);
    do_fetch("seq3", 32'h0000_000C, 32'hA000_0003);
    do_issue(0, 0, 0, 0);

    // beq at 0x10, imm -4, taken: 0x14 - 0x10 = 0x04
    do_fetch("beq_back", 32'h0000_0010, 32'h1400_FFFC);
    do_issue(1, 0, 1, 0);
    // beq at 0x04, imm 2, taken: 0x08 + 0x08 = 0x10
    do_fetch("beq_fwd", 32'h0000_0004, 32'h1400_0002);
    do_issue(1, 0, 1, 0);
    // beq at 0x10, zero=0: not taken
    do_fetch("beq_nt", 32'h0000_0010, 32'h1400_FFFC);
    check("beq_nt_plus4", pc_plus4, 32'h0000_0014);
    do_issue(1, 0, 0, 0);
    // beq at 0x14, imm 2: 0x18 + 0x08 = 0x20
    do_fetch("beq_20", 32'h0000_0014, 32'h1400_0002);
    do_issue(1, 0, 1, 0);
    // bne at 0x20, imm 3, zero=0: 0x24 + 0x0C = 0x30
    do_fetch("bne_t", 32'h0000_0020, 32'h1800_0003);
    do_issue(0, 1, 0, 0);
    // bne at 0x30, zero=1: not taken
    do_fetch("bne_nt", 32'h0000_0030, 32'h1800_0003);
    do_issue(0, 1, 1, 0);
    // beq at 0x34, imm -15: 0x38 - 0x3C wraps to 0xFFFF_FFFC
    do_fetch("neg_wrap", 32'h0000_0034, 32'h1000_FFF1);
    do_issue(1, 0, 1, 0);
    // Sequential advance from the top of the address space wraps to 0
    do_fetch("top", 32'hFFFF_FFFC, 32'hA000_0004);
    check("top_plus4", pc_plus4, 32'h0000_0000);
    do_issue(0, 0, 0, 0);
    check("wrap_req", {31'h0, imem_req}, 32'h1);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Climb to 0x4000_0000 with 8192 maximum forward branches (0x20000 each)
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_7FFF;
    advance    = 1'b1;
    branch     = 1'b1;
    zero       = 1'b1;
    for (int i = 0; i < 2 * 8192; i++) begin
      tick();
    end
    imem_ack = 1'b0;
    advance  = 1'b0;
    branch   = 1'b0;
    zero     = 1'b0;

    // j with branch also taken: jump target wins over 0x4000_0044
    do_fetch("j_vs_b", 32'h4000_0000, 32'h0800_0010);
    do_issue(1, 0, 1, 1);
    // plain j, target 0x20 -> 0x4000_0080
    do_fetch("j", 32'h4000_0040, 32'h0800_0020);
    do_issue(0, 0, 0, 1);

    // Reset while a fetch is pending, with ack arriving during and after reset
    check("pend_req", {31'h0, imem_req}, 32'h1);
    check("pend_addr", imem_addr, 32'h4000_0080);
    reset_n    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    tick();
    check("mid_rst_req", {31'h0, imem_req}, 32'h0);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
    check("mid_rst_instr", instr, 32'h0);
    reset_n = 1'b1;
    tick();
    check("late_ack_valid", {31'h0, instr_valid}, 32'h0);
    check("late_ack_instr", instr, 32'h0);
    imem_ack = 1'b0;
    do_fetch("restart", 32'h0000_0000, 32'hA000_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
